// File: rtl/ttt_ai_player.sv
// Tic-tac-toe move picker: scans for a winning line, then a blocking line, then
// falls back to a fixed cell order, one line or cell per clock.
module ttt_ai_player #(
  parameter int unsigned PREFER_CENTER = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ai_player,
  input  logic [17:0] board,
  input  logic        game_over,
  output logic        move_valid,
  output logic [3:0]  move_pos,
  output logic [1:0]  move_player,
  output logic        busy,
  output logic        no_move
);

  typedef enum logic [1:0] {Idle, WinScan, BlockScan, Fallback} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [17:0] snap_q, snap_d;
  logic [1:0]  ai_q, ai_d;
  logic        move_valid_d, no_move_d;
  logic [3:0]  move_pos_d;
  logic [1:0]  move_player_d;

  logic [1:0]  cells [9];
  logic [3:0]  c0, c1, c2, fb_cell;
  logic [1:0]  target;
  logic        hit;
  logic [3:0]  hit_pos;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      cells[i] = snap_q[2*i +: 2];
    end
  end

  always_comb begin
    unique case (idx_q[2:0])
      3'd0:    begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
      3'd1:    begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
      3'd2:    begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
      3'd3:    begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
      3'd4:    begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
      3'd5:    begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
      3'd6:    begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
      default: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
    endcase
  end

  always_comb begin
    fb_cell = idx_q;
    if (PREFER_CENTER != 0) begin
      case (idx_q)
        4'd0:    fb_cell = 4'd4;
        4'd1:    fb_cell = 4'd0;
        4'd2:    fb_cell = 4'd2;
        4'd3:    fb_cell = 4'd6;
        4'd4:    fb_cell = 4'd8;
        4'd5:    fb_cell = 4'd1;
        4'd6:    fb_cell = 4'd3;
        4'd7:    fb_cell = 4'd5;
        default: fb_cell = 4'd7;
      endcase
    end
  end

  // A hit needs two cells equal to the target side and the third strictly empty;
  // neutral 11 cells match neither.
  always_comb begin
    target  = (state_q == WinScan) ? ai_q : (2'd3 - ai_q);
    hit     = 1'b0;
    hit_pos = c2;
    if (cells[c0] == target && cells[c1] == target && cells[c2] == 2'b00) begin
      hit = 1'b1; hit_pos = c2;
    end else if (cells[c0] == target && cells[c2] == target && cells[c1] == 2'b00) begin
      hit = 1'b1; hit_pos = c1;
    end else if (cells[c1] == target && cells[c2] == target && cells[c0] == 2'b00) begin
      hit = 1'b1; hit_pos = c0;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    ai_d          = ai_q;
    move_valid_d  = 1'b0;
    no_move_d     = 1'b0;
    move_pos_d    = move_pos;
    move_player_d = move_player;
    unique case (state_q)
      Idle: begin
        if (start && !game_over && (ai_player == 2'd1 || ai_player == 2'd2)) begin
          snap_d  = board;
          ai_d    = ai_player;
          idx_d   = 4'd0;
          state_d = WinScan;
        end
      end
      WinScan, BlockScan: begin
        if (hit) begin
          move_valid_d  = 1'b1;
          move_pos_d    = hit_pos;
          move_player_d = ai_q;
          state_d       = Idle;
        end else if (idx_q == 4'd7) begin
          idx_d   = 4'd0;
          state_d = (state_q == WinScan) ? BlockScan : Fallback;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        if (cells[fb_cell] == 2'b00) begin
          move_valid_d  = 1'b1;
          move_pos_d    = fb_cell;
          move_player_d = ai_q;
          state_d       = Idle;
        end else if (idx_q == 4'd8) begin
          no_move_d = 1'b1;
          state_d   = Idle;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= Idle;
      idx_q       <= 4'd0;
      snap_q      <= 18'd0;
      ai_q        <= 2'd0;
      move_valid  <= 1'b0;
      no_move     <= 1'b0;
      move_pos    <= 4'd0;
      move_player <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      ai_q        <= ai_d;
      move_valid  <= move_valid_d;
      no_move     <= no_move_d;
      move_pos    <= move_pos_d;
      move_player <= move_player_d;
    end
  end

  assign busy = (state_q != Idle);

endmodule
